// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-select slice per cycle with valid/ready on both sides.
// Optional subtract mode (port sub) is enabled by defining NIBBLE_SERIAL_ADDER_SUB_EN.

module adder_4bits_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    // Upper pair is computed for both carry values and selected by the lower pair's carry
    always_comb begin
        lo   = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
        hi0  = {1'b0, a[3:2]} + {1'b0, b[3:2]};
        hi1  = hi0 + 3'd1;
        sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
        cout = lo[2] ? hi1[2] : hi0[2];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_shifted, b_eff;
    logic             carry, carry_init;
    logic [CW-1:0]    cnt;
    logic [1:0]       msb_r;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             accept, last_slice;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    always_comb begin
        b_eff      = sub ? ~b : b;
        carry_init = sub ? 1'b1 : cin;
    end
`else
    always_comb begin
        b_eff      = b;
        carry_init = cin;
    end
`endif

    adder_4bits_block u_nib (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters at the top so the first slice ends at bits 3:0 after N shifts
    if (WIDTH == 4) begin : g_single
        assign sum_shifted = nib_sum;
    end else begin : g_multi
        assign sum_shifted = {nib_sum, sum_sh[WIDTH-1:4]};
    end

    assign accept     = in_valid && in_ready;
    assign last_slice = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_slice) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            msb_r  <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_eff;
            carry <= carry_init;
            cnt   <= '0;
            msb_r <= {a[WIDTH-1], b_eff[WIDTH-1]};
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 4;
            b_sh   <= b_sh >> 4;
            sum_sh <= sum_shifted;
            carry  <= nib_cout;
            cnt    <= cnt + CW'(1);
        end
    end

    assign sum      = sum_sh;
    assign cout     = carry;
    assign overflow = (msb_r[1] == msb_r[0]) && (sum_sh[WIDTH-1] != msb_r[1]);
endmodule
